// File: rtl/sd1001_pkg.sv
// rtl/sd1001_pkg.sv - shared constants and state encoding for the 1001 framer
package sd1001_pkg;

  localparam int                  PREAMBLE_W    = 4;
  localparam logic [PREAMBLE_W-1:0] PREAMBLE    = 4'b1001;
  localparam logic [2:0]          STUFF_TRIGGER = 3'b100;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GUARD = 3'd1,
    PRE   = 3'd2,
    DATA  = 3'd3,
    STUFF = 3'd4
  } tx_state_e;

  // One counter serves both the preamble and the payload, so it must hold 0..3.
  function automatic int cnt_width(input int data_w);
    return (data_w > 4) ? $clog2(data_w) : 2;
  endfunction

endpackage

// File: rtl/sd1001_framer_tx_if.sv
// rtl/sd1001_framer_tx_if.sv - payload handshake and serial line bundle
interface sd1001_framer_tx_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              dout;
  logic              dout_en;
  logic              busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, dout, dout_en, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, dout, dout_en, busy
  );

endinterface

// File: rtl/sd1001_framer_tx.sv
// rtl/sd1001_framer_tx.sv - serialises payload words as 1001-preamble frames with zero stuffing
import sd1001_pkg::*;

module sd1001_framer_tx #(
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  sd1001_framer_tx_if.slave       bus
);

  localparam int CNT_W = cnt_width(DATA_W);

  tx_state_e               r_state;
  logic [DATA_W-1:0]       r_shift;
  logic [PREAMBLE_W-1:0]   r_pre;
  logic [CNT_W-1:0]        r_cnt;
  logic [2:0]              r_hist;
  logic                    r_dout;
  logic                    r_dout_en;

  logic                    w_bit;
  logic                    w_accept;
  logic [2:0]              w_hist_next;

  // The state names the bit that goes onto the line at the next edge.
  always_comb begin
    w_bit = 1'b0;
    case (r_state)
      PRE:     w_bit = r_pre[PREAMBLE_W-1];
      DATA:    w_bit = r_shift[DATA_W-1];
      default: w_bit = 1'b0;
    endcase
  end

  assign w_hist_next  = {r_hist[1:0], w_bit};
  assign w_accept     = bus.in_valid && (r_state == IDLE);

  assign bus.in_ready = (r_state == IDLE);
  assign bus.busy     = (r_state != IDLE);
  assign bus.dout     = r_dout;
  assign bus.dout_en  = r_dout_en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_pre     <= '0;
      r_cnt     <= '0;
      r_hist    <= 3'b000;
      r_dout    <= 1'b0;
      r_dout_en <= 1'b0;
    end else begin
      r_hist    <= w_hist_next;
      r_dout    <= w_bit;
      r_dout_en <= (r_state != IDLE);

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= bus.in_data;
            r_pre   <= PREAMBLE;
            r_cnt   <= '0;
            // The idle zero leaving now is part of the history the guard check sees.
            r_state <= (w_hist_next == STUFF_TRIGGER) ? GUARD : PRE;
          end
        end

        GUARD: r_state <= PRE;

        PRE: begin
          r_pre <= r_pre << 1;
          if (r_cnt == CNT_W'(PREAMBLE_W - 1)) begin
            r_cnt   <= '0;
            r_state <= (w_hist_next == STUFF_TRIGGER) ? STUFF : DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          r_shift <= r_shift << 1;
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            r_state <= IDLE;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= (w_hist_next == STUFF_TRIGGER) ? STUFF : DATA;
          end
        end

        STUFF: r_state <= DATA;

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd1001_framer_tx.sv
// tb/tb_sd1001_framer_tx.sv - self-checking bench for sd1001_framer_tx against a line-level model
module tb_sd1001_framer_tx;

  logic clk = 1'b0;
  logic reset = 1'b0;

  sd1001_framer_tx_if #(.DATA_W(8)) bus ();

  sd1001_framer_tx #(.DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        q[$];
  logic [2:0]  line = 3'b000;
  logic        exp_dout = 1'b0;
  logic        exp_en = 1'b0;
  logic [3:0]  win = 4'b0000;
  int          det = 0;
  int          frames = 0;
  logic [31:0] cap = '0;
  int          cap_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame = optional guard, preamble, then payload MSB-first with a 0 after every 100.
  task automatic build_frame(input logic [7:0] d);
    logic [2:0] h;
    h = line;
    if (h == 3'b100) begin q.push_back(1'b0); h = {h[1:0], 1'b0}; end
    for (int i = 3; i >= 0; i--) begin
      q.push_back(4'b1001 >> i);
      h = {h[1:0], 1'(4'b1001 >> i)};
    end
    for (int i = 7; i >= 0; i--) begin
      if (h == 3'b100) begin q.push_back(1'b0); h = {h[1:0], 1'b0}; end
      q.push_back(d[i]);
      h = {h[1:0], d[i]};
    end
  endtask

  task automatic step();
    logic acc;
    @(posedge clk);
    if (!reset) begin
      q.delete();
      line = 3'b000; exp_dout = 1'b0; exp_en = 1'b0;
      win = 4'b0000; det = 0; frames = 0;
    end else begin
      acc = bus.in_valid && (q.size() == 0);
      if (q.size() != 0) begin exp_dout = q.pop_front(); exp_en = 1'b1; end
      else begin exp_dout = 1'b0; exp_en = 1'b0; end
      line = {line[1:0], exp_dout};
      if (acc) begin build_frame(bus.in_data); frames++; end
    end
    #1;
    chk("dout",     32'(bus.dout),     32'(exp_dout));
    chk("dout_en",  32'(bus.dout_en),  32'(exp_en));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() == 0));
    chk("busy",     32'(bus.busy),     32'(q.size() != 0));
    if (reset) begin
      win = {win[2:0], bus.dout};
      if (win == 4'b1001) det++;
    end
    if (bus.dout_en) begin cap = {cap[30:0], bus.dout}; cap_n++; end
  endtask

  task automatic chk_model(input string name, input logic [31:0] lit, input int len);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < q.size(); i++) v = {v[30:0], q[i]};
    chk({name, "_model"}, v, lit);
    chk({name, "_model_len"}, 32'(q.size()), 32'(len));
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!bus.in_ready && k < 60) begin step(); k++; end
    chk({name, "_idle_timeout"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic [31:0] lit, input int len, input string name);
    bus.in_valid = 1'b1; bus.in_data = d; cap = '0; cap_n = 0;
    step();
    bus.in_valid = 1'b0; bus.in_data = 8'($urandom);
    chk_model(name, lit, len);
    wait_idle(name);
    chk({name, "_line"}, cap, lit);
    chk({name, "_len"}, 32'(cap_n), 32'(len));
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    reset = 1'b0;
    repeat (3) step();
    chk("reset_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_dout",  32'(bus.dout),     32'd0);

    reset = 1'b1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = 8'($urandom);
      step();
      chk("idle_line", {29'd0, bus.dout, bus.dout_en, bus.busy}, 32'd0);
      chk("idle_ready", 32'(bus.in_ready), 32'd1);
    end

    send(8'hA5, 32'b1001101000101, 13, "a5");

    det = 0;
    send(8'h99, 32'b10011000110001, 14, "x99");
    repeat (4) step();
    chk("x99_detections", 32'(det), 32'd1);

    bus.in_valid = 1'b1; bus.in_data = 8'h02; cap = '0; cap_n = 0;
    step();
    bus.in_data = 8'h01;
    chk_model("b2b_f1", 32'b1001000000010, 13);
    wait_idle("b2b_f1");
    chk("b2b_f1_line", cap, 32'b1001000000010);
    chk("b2b_f1_len", 32'(cap_n), 32'd13);
    cap = '0; cap_n = 0;
    step();
    bus.in_valid = 1'b0;
    chk_model("b2b_f2", 32'b01001000000001, 14);
    wait_idle("b2b_f2");
    chk("b2b_f2_line", cap, 32'b01001000000001);
    chk("b2b_f2_len", 32'(cap_n), 32'd14);

    send(8'h00, 32'b1001000000000, 13, "x00");

    bus.in_valid = 1'b1; bus.in_data = 8'hFF;
    step();
    bus.in_valid = 1'b0;
    repeat (6) step();
    reset = 1'b0;
    step();
    chk("midrst_state", {28'd0, bus.dout, bus.dout_en, bus.busy, bus.in_ready}, 32'b0001);
    reset = 1'b1;
    send(8'h5A, 32'b100101011010, 12, "post_rst");

    det = 0; frames = 0;
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 149) != 0);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_data  = ($urandom_range(0, 3) == 0) ? 8'h99 : 8'($urandom);
      step();
    end
    reset = 1'b1;
    bus.in_valid = 1'b0;
    wait_idle("rand_end");
    repeat (4) step();
    chk("rand_detections", 32'(det), 32'(frames));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
